pwm_timebase: RTL and testbench

PWM_TIMEBASE -- requirements
Module: pwm_timebase

---
 rtl/pwm_timebase_if.sv | 47 ++++
 rtl/pwm_timebase.sv | 92 +++++++++
 tb/tb_pwm_timebase.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_timebase_if.sv
// pwm_timebase_if
//   Configuration and status bundle between the register front end and the
//   PWM timebase.
//   master : drives prescale/period/sync_update and the software channel
//            settings, observes the timebase status and shadowed settings.
//   slave  : the timebase itself.
//   Signals:
//     prescale_reg, period_reg      prescale divide value, period terminal count
//     sync_update                   1 = shadow loads only at period wrap
//     enable_in, posedge_in,
//     negedge_in                    software channel settings (flat, channel n
//                                   at bits [n*APB_DWIDTH +: APB_DWIDTH])
//     period_cnt, sync_pulse,
//     period_end                    registered timebase status
//     pwm_enable_reg,
//     pwm_posedge_reg,
//     pwm_negedge_reg               shadowed channel settings
interface pwm_timebase_if #(
  parameter int PWM_NUM    = 8,
  parameter int APB_DWIDTH = 8
);
  logic [APB_DWIDTH-1:0]         prescale_reg;
  logic [APB_DWIDTH-1:0]         period_reg;
  logic                          sync_update;
  logic [PWM_NUM-1:0]            enable_in;
  logic [PWM_NUM*APB_DWIDTH-1:0] posedge_in;
  logic [PWM_NUM*APB_DWIDTH-1:0] negedge_in;

  logic [APB_DWIDTH-1:0]         period_cnt;
  logic                          sync_pulse;
  logic                          period_end;
  logic [PWM_NUM-1:0]            pwm_enable_reg;
  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_posedge_reg;
  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_negedge_reg;

  modport master (
    output prescale_reg, period_reg, sync_update, enable_in, posedge_in, negedge_in,
    input  period_cnt, sync_pulse, period_end,
           pwm_enable_reg, pwm_posedge_reg, pwm_negedge_reg
  );

  modport slave (
    input  prescale_reg, period_reg, sync_update, enable_in, posedge_in, negedge_in,
    output period_cnt, sync_pulse, period_end,
           pwm_enable_reg, pwm_posedge_reg, pwm_negedge_reg
  );
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase
//   Prescaled period counter for a bank of PWM channels, plus shadow
//   registers that hand the software channel settings to the PWM generator.
//   A tick (sync_pulse) occurs every prescale_reg+1 PCLK cycles; each tick
//   advances period_cnt, which wraps to 0 after reaching period_reg, so one
//   period lasts (prescale_reg+1)*(period_reg+1) cycles.
//   Ports:
//     PCLK     system clock, rising edge
//     PRESETN  asynchronous active-low reset
//     bus      pwm_timebase_if.slave (configuration in, status/shadows out)
//   Build option:
//     PWM_SHADOW_SYNC_EN  when defined, sync_update = 1 restricts shadow loads
//                         to the wrap edge; when undefined, shadows load on
//                         every edge and sync_update is ignored.
module pwm_timebase #(
  parameter int PWM_NUM    = 8,
  parameter int APB_DWIDTH = 8
) (
  input  logic           PCLK,
  input  logic           PRESETN,
  pwm_timebase_if.slave  bus
);

  logic [APB_DWIDTH-1:0]         prescale_cnt;
  logic [APB_DWIDTH-1:0]         period_cnt;
  logic                          sync_pulse;
  logic                          period_end;
  logic [PWM_NUM-1:0]            pwm_enable_reg;
  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_posedge_reg;
  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_negedge_reg;

  logic tick_now;
  logic wrap_now;
  logic shadow_load;

  // >= rather than == so that lowering prescale_reg/period_reg below the
  // running count forces an immediate tick/wrap instead of counting round.
  assign tick_now = (prescale_cnt >= bus.prescale_reg);
  assign wrap_now = tick_now && (period_cnt >= bus.period_reg);

`ifdef PWM_SHADOW_SYNC_EN
  assign shadow_load = !bus.sync_update || wrap_now;
`else
  logic unused_sync_update;
  assign unused_sync_update = bus.sync_update;
  assign shadow_load = 1'b1;
`endif

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      prescale_cnt <= '0;
      period_cnt   <= '0;
      sync_pulse   <= 1'b0;
      period_end   <= 1'b0;
    end else if (tick_now) begin
      prescale_cnt <= '0;
      sync_pulse   <= 1'b1;
      if (wrap_now) begin
        period_cnt <= '0;
        period_end <= 1'b1;
      end else begin
        period_cnt <= period_cnt + APB_DWIDTH'(1);
        period_end <= 1'b0;
      end
    end else begin
      prescale_cnt <= prescale_cnt + APB_DWIDTH'(1);
      sync_pulse   <= 1'b0;
      period_end   <= 1'b0;
    end
  end

  // All channels and all three fields load on the same edge.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      pwm_enable_reg  <= '0;
      pwm_posedge_reg <= '0;
      pwm_negedge_reg <= '0;
    end else if (shadow_load) begin
      pwm_enable_reg  <= bus.enable_in;
      pwm_posedge_reg <= bus.posedge_in;
      pwm_negedge_reg <= bus.negedge_in;
    end
  end

  assign bus.period_cnt      = period_cnt;
  assign bus.sync_pulse      = sync_pulse;
  assign bus.period_end      = period_end;
  assign bus.pwm_enable_reg  = pwm_enable_reg;
  assign bus.pwm_posedge_reg = pwm_posedge_reg;
  assign bus.pwm_negedge_reg = pwm_negedge_reg;

endmodule

// File: tb/tb_pwm_timebase.sv
module tb_pwm_timebase;
  localparam int PWM_NUM    = 8;
  localparam int APB_DWIDTH = 8;

`ifdef PWM_SHADOW_SYNC_EN
  localparam bit SHADOW_SYNC = 1'b1;
`else
  localparam bit SHADOW_SYNC = 1'b0;
`endif

  localparam logic [63:0] POS_A = 64'h1010_1010_1010_1010;
  localparam logic [63:0] POS_B = 64'h2020_2020_2020_2020;
  localparam logic [63:0] NEG_A = 64'h3333_3333_3333_3333;
  localparam logic [63:0] NEG_B = 64'h4444_4444_4444_4444;

  logic PCLK;
  logic PRESETN;
  int   checks;
  int   errors;

  pwm_timebase_if #(.PWM_NUM(PWM_NUM), .APB_DWIDTH(APB_DWIDTH)) bus ();

  pwm_timebase #(.PWM_NUM(PWM_NUM), .APB_DWIDTH(APB_DWIDTH)) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] prescale;
    logic [7:0] period;
    int         cycles;
    logic [7:0] exp_cnt;
    logic       exp_sync;
    logic       exp_end;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Holds reset across one rising edge and releases on a falling edge, so the
  // next rising edge is edge 1 after reset.
  task automatic do_reset();
    PRESETN = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESETN = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    PRESETN = 1'b1;
    bus.prescale_reg = 8'd3;
    bus.period_reg   = 8'd4;
    bus.sync_update  = 1'b0;
    bus.enable_in    = 8'hA5;
    bus.posedge_in   = POS_A;
    bus.negedge_in   = NEG_A;

    //            pre  per  cyc  cnt  sync end
    vecs[0]  = '{8'd3, 8'd4, 3,  8'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'd3, 8'd4, 4,  8'd1, 1'b1, 1'b0};
    vecs[2]  = '{8'd3, 8'd4, 5,  8'd1, 1'b0, 1'b0};
    vecs[3]  = '{8'd3, 8'd4, 16, 8'd4, 1'b1, 1'b0};
    vecs[4]  = '{8'd3, 8'd4, 20, 8'd0, 1'b1, 1'b1};
    vecs[5]  = '{8'd3, 8'd4, 21, 8'd0, 1'b0, 1'b0};
    vecs[6]  = '{8'd0, 8'd2, 1,  8'd1, 1'b1, 1'b0};
    vecs[7]  = '{8'd0, 8'd2, 2,  8'd2, 1'b1, 1'b0};
    vecs[8]  = '{8'd0, 8'd2, 3,  8'd0, 1'b1, 1'b1};
    vecs[9]  = '{8'd0, 8'd2, 4,  8'd1, 1'b1, 1'b0};
    vecs[10] = '{8'd0, 8'd2, 6,  8'd0, 1'b1, 1'b1};
    vecs[11] = '{8'd1, 8'd0, 1,  8'd0, 1'b0, 1'b0};
    vecs[12] = '{8'd1, 8'd0, 2,  8'd0, 1'b1, 1'b1};
    vecs[13] = '{8'd1, 8'd0, 3,  8'd0, 1'b0, 1'b0};

    // Reset state while PRESETN is held low.
    @(negedge PCLK);
    PRESETN = 1'b0;
    step(2);
    check("rst_period_cnt", 64'(bus.period_cnt), 64'd0);
    check("rst_sync_pulse", 64'(bus.sync_pulse), 64'd0);
    check("rst_period_end", 64'(bus.period_end), 64'd0);
    check("rst_enable", 64'(bus.pwm_enable_reg), 64'd0);
    check("rst_posedge", bus.pwm_posedge_reg, 64'd0);
    check("rst_negedge", bus.pwm_negedge_reg, 64'd0);

    // Table: counts/ticks N edges after reset release.
    for (int i = 0; i < 14; i++) begin
      bus.prescale_reg = vecs[i].prescale;
      bus.period_reg   = vecs[i].period;
      do_reset();
      step(vecs[i].cycles);
      check($sformatf("vec%0d_period_cnt", i), 64'(bus.period_cnt), 64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_sync_pulse", i), 64'(bus.sync_pulse), 64'(vecs[i].exp_sync));
      check($sformatf("vec%0d_period_end", i), 64'(bus.period_end), 64'(vecs[i].exp_end));
      check($sformatf("vec%0d_enable", i), 64'(bus.pwm_enable_reg), 64'hA5);
    end

    // period_reg lowered below the running count.
    bus.prescale_reg = 8'd0;
    bus.period_reg   = 8'd250;
    do_reset();
    step(200);
    check("shrink_pre_cnt", 64'(bus.period_cnt), 64'd200);
    bus.period_reg = 8'd50;
    step(1);
    check("shrink_wrap_cnt", 64'(bus.period_cnt), 64'd0);
    check("shrink_wrap_end", 64'(bus.period_end), 64'd1);
    step(1);
    check("shrink_next_cnt", 64'(bus.period_cnt), 64'd1);
    check("shrink_next_end", 64'(bus.period_end), 64'd0);

    // prescale_reg lowered below the running prescale count.
    bus.prescale_reg = 8'd10;
    bus.period_reg   = 8'd5;
    do_reset();
    step(5);
    check("prelow_before_sync", 64'(bus.sync_pulse), 64'd0);
    bus.prescale_reg = 8'd2;
    step(1);
    check("prelow_tick_sync", 64'(bus.sync_pulse), 64'd1);
    check("prelow_tick_cnt", 64'(bus.period_cnt), 64'd1);
    step(1);
    check("prelow_after_sync", 64'(bus.sync_pulse), 64'd0);
    step(2);
    check("prelow_next_sync", 64'(bus.sync_pulse), 64'd1);
    check("prelow_next_cnt", 64'(bus.period_cnt), 64'd2);

    // Asynchronous reset mid-period, then restart.
    bus.prescale_reg = 8'd3;
    bus.period_reg   = 8'd4;
    do_reset();
    step(12);
    check("midrst_pre_cnt", 64'(bus.period_cnt), 64'd3);
    #2;
    PRESETN = 1'b0;
    #1;
    check("midrst_cnt", 64'(bus.period_cnt), 64'd0);
    check("midrst_sync", 64'(bus.sync_pulse), 64'd0);
    check("midrst_end", 64'(bus.period_end), 64'd0);
    check("midrst_enable", 64'(bus.pwm_enable_reg), 64'd0);
    check("midrst_posedge", bus.pwm_posedge_reg, 64'd0);
    @(negedge PCLK);
    PRESETN = 1'b1;
    step(3);
    check("midrst_restart_sync0", 64'(bus.sync_pulse), 64'd0);
    check("midrst_restart_cnt0", 64'(bus.period_cnt), 64'd0);
    step(1);
    check("midrst_restart_sync1", 64'(bus.sync_pulse), 64'd1);
    check("midrst_restart_cnt1", 64'(bus.period_cnt), 64'd1);

    // Shadow update timing: period of 8 cycles, wrap on edge 8.
    bus.prescale_reg = 8'd1;
    bus.period_reg   = 8'd3;
    bus.sync_update  = 1'b0;
    bus.enable_in    = 8'h0F;
    bus.posedge_in   = POS_A;
    bus.negedge_in   = NEG_A;
    do_reset();
    step(1);
    check("shd_load_posedge", bus.pwm_posedge_reg, POS_A);
    check("shd_load_negedge", bus.pwm_negedge_reg, NEG_A);
    bus.sync_update = 1'b1;
    step(2);
    bus.enable_in  = 8'hF0;
    bus.posedge_in = POS_B;
    bus.negedge_in = NEG_B;
    step(1);
    check("shd_e4_posedge", bus.pwm_posedge_reg, SHADOW_SYNC ? POS_A : POS_B);
    check("shd_e4_enable", 64'(bus.pwm_enable_reg), SHADOW_SYNC ? 64'h0F : 64'hF0);
    step(3);
    check("shd_e7_cnt", 64'(bus.period_cnt), 64'd3);
    check("shd_e7_posedge", bus.pwm_posedge_reg, SHADOW_SYNC ? POS_A : POS_B);
    check("shd_e7_negedge", bus.pwm_negedge_reg, SHADOW_SYNC ? NEG_A : NEG_B);
    step(1);
    check("shd_wrap_cnt", 64'(bus.period_cnt), 64'd0);
    check("shd_wrap_end", 64'(bus.period_end), 64'd1);
    check("shd_wrap_posedge", bus.pwm_posedge_reg, POS_B);
    check("shd_wrap_negedge", bus.pwm_negedge_reg, NEG_B);
    check("shd_wrap_enable", 64'(bus.pwm_enable_reg), 64'hF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
